// File: rtl/line_clear_engine.sv
// Row-clear engine: scans the board bottom-up, drops full rows, compacts the
// rest downward, zero-fills the top and accumulates a saturating score.
module line_clear_engine #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int XW      = 4,
  parameter int YW      = 5,
  parameter int SCORE_W = 5
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [YW-1:0]      lines_cleared,
  output logic [SCORE_W-1:0] score,
  output logic [XW-1:0]      board_rx,
  output logic [YW-1:0]      board_ry,
  input  logic               board_rdata,
  output logic               board_we,
  output logic [XW-1:0]      board_wx,
  output logic [YW-1:0]      board_wy,
  output logic               board_wdata
);

  localparam int CW   = XW + 1;
  localparam int SW   = ((SCORE_W > YW) ? SCORE_W : YW) + 1;
  localparam int SMAX = 2**SCORE_W - 1;
  localparam logic signed [YW:0] ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_COPY, S_FILL, S_DONE} state_t;

  state_t                state_q, state_d;
  logic signed [YW:0]    src_q, src_d, dst_q, dst_d;
  logic [BOARD_W-1:0]    rowbuf_q, rowbuf_d;
  logic [CW-1:0]         col_q, col_d;
  logic [YW-1:0]         cnt_q, cnt_d, lines_q, lines_d;
  logic [SCORE_W-1:0]    score_q, score_d, score_sat;
  logic [SW-1:0]         sum;
  logic                  reading, writing, wbit;

  // Shared successor rule after src/dst have been updated.
  function automatic state_t advance(input logic signed [YW:0] s, input logic signed [YW:0] d);
    if (!s[YW])      return S_READ;
    else if (!d[YW]) return S_FILL;
    else             return S_DONE;
  endfunction

  always_ff @(posedge CLOCK_50 or posedge resetn) begin
    if (resetn) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rowbuf_q <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      lines_q  <= '0;
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rowbuf_q <= rowbuf_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      lines_q  <= lines_d;
      score_q  <= score_d;
    end
  end

  always_comb begin
    sum       = SW'(score_q) + SW'(cnt_q);
    score_sat = (sum > SW'(SMAX)) ? '1 : SCORE_W'(sum);
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rowbuf_d = rowbuf_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    lines_d  = lines_q;
    score_d  = score_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = (YW+1)'(BOARD_H - 1);
          dst_d   = (YW+1)'(BOARD_H - 1);
          cnt_d   = '0;
          col_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // RAM data lags the address by one cycle, so cycle c captures column c-1.
        for (int unsigned i = 0; i < BOARD_W; i++)
          if (col_q == CW'(i + 1)) rowbuf_d[i] = board_rdata;
        if (col_q == CW'(BOARD_W)) begin
          col_d   = '0;
          state_d = S_EVAL;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_EVAL: begin
        if (&rowbuf_q) begin
          cnt_d   = cnt_q + YW'(1);
          src_d   = src_q - ONE;
          state_d = advance(src_d, dst_q);
        end else if (src_q != dst_q) begin
          state_d = S_COPY;
        end else begin
          src_d   = src_q - ONE;
          dst_d   = dst_q - ONE;
          state_d = advance(src_d, dst_d);
        end
      end
      S_COPY: begin
        if (col_q == CW'(BOARD_W - 1)) begin
          col_d   = '0;
          src_d   = src_q - ONE;
          dst_d   = dst_q - ONE;
          state_d = advance(src_d, dst_d);
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_FILL: begin
        if (col_q == CW'(BOARD_W - 1)) begin
          col_d   = '0;
          dst_d   = dst_q - ONE;
          state_d = dst_d[YW] ? S_DONE : S_FILL;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DONE: begin
        lines_d = cnt_q;
        score_d = score_sat;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    lines_cleared = done ? cnt_q : lines_q;
    score         = done ? score_sat : score_q;
    reading       = (state_q == S_READ) && (col_q < CW'(BOARD_W));
    writing       = (state_q == S_COPY) || (state_q == S_FILL);
    board_rx      = reading ? col_q[XW-1:0] : '0;
    board_ry      = reading ? src_q[YW-1:0] : '0;
    board_we      = writing;
    board_wx      = writing ? col_q[XW-1:0] : '0;
    board_wy      = writing ? dst_q[YW-1:0] : '0;
    wbit          = 1'b0;
    for (int unsigned i = 0; i < BOARD_W; i++)
      if ((state_q == S_COPY) && (col_q == CW'(i))) wbit = rowbuf_q[i];
    board_wdata   = wbit;
  end

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: board RAM model, directed boards, queue-based
// scoreboard checking results, completion time and write stream.
module tb_line_clear_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done;
  logic [4:0] lines_cleared;
  logic [2:0] score;
  logic [3:0] board_rx, board_wx;
  logic [4:0] board_ry, board_wy;
  logic       board_rdata, board_we, board_wdata;

  logic [9:0] mem [0:31];
  logic       ld_we = 1'b0;
  logic [4:0] ld_y = '0;
  logic [9:0] ld_row = '0;

  typedef struct {
    int lines;
    int score;
    int t;
    int writes;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  line_clear_engine #(.SCORE_W(3)) dut (
    .CLOCK_50      (clk),
    .resetn        (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .score         (score),
    .board_rx      (board_rx),
    .board_ry      (board_ry),
    .board_rdata   (board_rdata),
    .board_we      (board_we),
    .board_wx      (board_wx),
    .board_wy      (board_wy),
    .board_wdata   (board_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    board_rdata <= mem[board_ry][board_rx];
    if (board_we) mem[board_wy][board_wx] <= board_wdata;
    if (ld_we)    mem[ld_y] <= ld_row;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse and audits the write stream.
  initial begin
    int   wr_cnt;
    int   exp_wx;
    exp_t e;
    wr_cnt = 0;
    exp_wx = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_cnt = 0;
        exp_wx = 0;
        chk("reset_outputs", {busy, done, lines_cleared, score, board_rx, board_ry,
                              board_we, board_wx, board_wy, board_wdata}, 0);
      end else begin
        if (board_we) begin
          wr_cnt++;
          chk("write_col_order", board_wx, exp_wx);
          exp_wx = (board_wx == 4'd9) ? 0 : int'(board_wx) + 1;
        end else if (exp_wx != 0) begin
          chk("write_gap_col", 0, exp_wx);
          exp_wx = 0;
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("lines_cleared", lines_cleared, e.lines);
            chk("score", score, e.score);
            chk("done_edge", cyc - start_cyc, e.t);
            chk("write_count", wr_cnt, e.writes);
          end
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic load_row(input int r, input logic [9:0] v);
    @(negedge clk);
    ld_we  = 1'b1;
    ld_y   = 5'(r);
    ld_row = v;
    @(negedge clk);
    ld_we  = 1'b0;
  endtask

  task automatic clear_board();
    for (int r = 0; r < 20; r++) load_row(r, 10'h000);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic run(input int lines, input int sc, input int t, input int writes, input bit poke);
    exp_t e;
    e.lines  = lines;
    e.score  = sc;
    e.t      = t;
    e.writes = writes;
    exp_q.push_back(e);
    pulse_start();
    if (poke) begin
      repeat (50) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 3000 cycles");
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic rows_zero_except(input int r1, input int r2);
    for (int r = 0; r < 20; r++)
      if (r != r1 && r != r2) chk($sformatf("row%0d_zero", r), mem[r], 0);
  endtask

  initial begin
    int n;
    // Reset held for 5 cycles with start toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = ~start;
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;

    // Empty board.
    clear_board();
    run(0, 0, 240, 0, 1'b0);
    rows_zero_except(-1, -1);

    // Bottom row full, row 18 survives into row 19.
    clear_board();
    load_row(19, 10'h3FF);
    load_row(18, 10'b0000000101);
    run(1, 1, 440, 200, 1'b0);
    chk("r1_row19", mem[19], 10'b0000000101);
    rows_zero_except(19, -1);

    // Four bottom rows full.
    clear_board();
    for (int r = 16; r < 20; r++) load_row(r, 10'h3FF);
    load_row(15, 10'b1000000001);
    run(4, 5, 440, 200, 1'b0);
    chk("r2_row19", mem[19], 10'b1000000001);
    rows_zero_except(19, -1);

    // Extra start while busy is ignored; board has no full rows.
    run(0, 5, 240, 0, 1'b1);
    chk("r3_row19", mem[19], 10'b1000000001);

    // Abort in the middle of a COPY.
    clear_board();
    load_row(19, 10'h3FF);
    load_row(18, 10'h003);
    pulse_start();
    for (int i = 0; i < 500 && !board_we; i++) @(negedge clk);
    chk("copy_reached", board_we, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_we", board_we, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (board_we || busy) n++;
    end
    chk("idle_after_abort", n, 0);

    // Saturation: three 4-line runs on a 3-bit score.
    clear_board();
    for (int r = 16; r < 20; r++) load_row(r, 10'h3FF);
    run(4, 4, 440, 200, 1'b0);
    rows_zero_except(-1, -1);

    clear_board();
    for (int r = 16; r < 20; r++) load_row(r, 10'h3FF);
    run(4, 7, 440, 200, 1'b0);

    clear_board();
    load_row(19, 10'h3FF);
    load_row(17, 10'h3FF);
    load_row(14, 10'h3FF);
    load_row(12, 10'h3FF);
    load_row(18, 10'h001);
    load_row(13, 10'h200);
    run(4, 7, 440, 200, 1'b0);
    chk("r6_row19", mem[19], 10'h001);
    chk("r6_row16", mem[16], 10'h200);
    rows_zero_except(19, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

endmodule
